// File: rtl/bit_stream_unpacker.sv
// bit_stream_unpacker: collects a serial bit stream into two parallel buses.
//
// Ports:
//   clk      - clock; all state changes on its rising edge
//   rst_n    - asynchronous active-low reset
//   s_valid  - serial bit offered
//   s_ready  - block accepts a serial bit (high in IDLE and COLLECT)
//   s_data   - serial data bit
//   s_first  - marks the first bit of a frame
//   o0       - first unpacked bus  [LEFT0:RIGHT0]
//   o1       - second unpacked bus [LEFT1:RIGHT1]
//   m_valid  - o0/o1 hold a complete frame
//   m_ready  - consumer takes the frame
//   err      - one-cycle pulse on any frame abort or discard
//
// Optional feature: define BIT_STREAM_UNPACKER_PARITY_EN to append an even
// parity bit to every frame; a parity mismatch discards the frame.
module bit_stream_unpacker #(
    parameter int LEFT0   = 2,
    parameter int RIGHT0  = -2,
    parameter int LEFT1   = -2,
    parameter int RIGHT1  = 2,
    parameter int TIMEOUT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_data,
    input  logic                 s_first,
    output logic [LEFT0:RIGHT0]  o0,
    output logic [LEFT1:RIGHT1]  o1,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 err
);
    localparam int W0  = ((LEFT0 > RIGHT0) ? LEFT0 - RIGHT0 : RIGHT0 - LEFT0) + 1;
    localparam int W1  = ((LEFT1 > RIGHT1) ? LEFT1 - RIGHT1 : RIGHT1 - LEFT1) + 1;
    localparam int N   = W0 + W1;
`ifdef BIT_STREAM_UNPACKER_PARITY_EN
    localparam int FL  = N + 1;
`else
    localparam int FL  = N;
`endif
    // The final bit of a frame is never stored: it is either the last data
    // bit (consumed straight from s_data) or the parity bit.
    localparam int SW  = FL - 1;
    localparam int CW  = $clog2(FL);
    localparam int IW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TM1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   sh, sh_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   idle, idle_n;
    logic [N-1:0]    fd;
    logic            acc, last, tmo, load, err_n;

    assign acc     = s_valid & s_ready;
    assign last    = cnt == CW'(FL - 1);
    assign tmo     = (TIMEOUT != 0) && (idle == IW'(TM1));
    assign m_valid = state == HOLD;
`ifdef BIT_STREAM_UNPACKER_PARITY_EN
    assign fd = sh;
`else
    assign fd = {sh, s_data};
`endif

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        idle_n  = idle;
        load    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (acc && s_first) begin
                    sh_n    = SW'(s_data);
                    cnt_n   = CW'(1);
                    state_n = COLLECT;
                end else if (acc) begin
                    err_n = 1'b1;
                end
            end
            COLLECT: begin
                if (acc) begin
                    idle_n = '0;
                    if (s_first) begin
                        err_n = 1'b1;
                        sh_n  = SW'(s_data);
                        cnt_n = CW'(1);
                    end else if (last) begin
                        cnt_n = '0;
`ifdef BIT_STREAM_UNPACKER_PARITY_EN
                        // Even parity: data XOR parity bit must be zero.
                        load    = (^sh) == s_data;
                        err_n   = (^sh) != s_data;
                        state_n = ((^sh) == s_data) ? HOLD : IDLE;
`else
                        load    = 1'b1;
                        state_n = HOLD;
`endif
                    end else begin
                        sh_n  = SW'({sh, s_data});
                        cnt_n = cnt + 1'b1;
                    end
                end else if (tmo) begin
                    err_n   = 1'b1;
                    cnt_n   = '0;
                    idle_n  = '0;
                    state_n = IDLE;
                end else begin
                    idle_n = (idle == IW'(TIMEOUT)) ? idle : idle + 1'b1;
                end
            end
            HOLD: begin
                state_n = m_ready ? IDLE : HOLD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            idle    <= '0;
            o0      <= '0;
            o1      <= '0;
            err     <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            cnt     <= cnt_n;
            idle    <= idle_n;
            err     <= err_n;
            // Registered so it stays low through reset and rises on the first edge after.
            s_ready <= state_n != HOLD;
            if (load) begin
                o0 <= fd[N-1:W1];
                o1 <= fd[W1-1:0];
            end
        end
    end
endmodule

// File: tb/tb_bit_stream_unpacker.sv
// tb_bit_stream_unpacker: directed self-checking bench for bit_stream_unpacker.
module tb_bit_stream_unpacker;
`ifdef BIT_STREAM_UNPACKER_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_data = 1'b0, s_first = 1'b0, m_ready = 1'b1;
    logic s_ready, m_valid, err;
    logic [2:-2] o0;
    logic [-2:2] o1;
    logic [9:0] fr_a = 10'b1011001110;
    logic [9:0] fr_b = 10'b0110110001;
    int tests = 0, fails = 0, err_cnt = 0;

    bit_stream_unpacker dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_first(s_first), .o0(o0), .o1(o1), .m_valid(m_valid), .m_ready(m_ready), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (err) err_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic d, input logic f);
        s_valid = v;
        s_data  = d;
        s_first = f;
    endtask

    task automatic send_part(input logic [9:0] b, input int n, input logic flag);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, b[9-i], flag && i == 0);
            tick;
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [9:0] b, input logic pbad);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, b[9-i], i == 0);
            tick;
        end
`ifdef BIT_STREAM_UNPACKER_PARITY_EN
        drive(1'b1, (^b) ^ pbad, 1'b0);
        tick;
`else
        if (pbad) $display("note: parity not built, frame sent without parity");
`endif
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        tests++;
        if ({o0, o1, m_valid, s_ready, err} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0", {o0, o1, m_valid, s_ready, err});
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_before_edge: got %b required 0", s_ready);
        end
        tick;
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_after_edge: got %b required 1", s_ready);
        end
    endtask

    task automatic test_basic;
        int mv_first, mv_n, e0;
        logic sr_hold;
        mv_first = -1;
        mv_n = 0;
        sr_hold = 1'b1;
        e0 = err_cnt;
        m_ready = 1'b1;
        for (int c = 0; c < FL + 3; c++) begin
            if (c < 10) drive(1'b1, fr_a[9-c], c == 0);
            else if (c == 10 && FL == 11) drive(1'b1, ^fr_a, 1'b0);
            else drive(1'b0, 1'b0, 1'b0);
            tick;
            if (m_valid) begin
                mv_n++;
                sr_hold = s_ready;
                if (mv_first < 0) mv_first = c + 1;
            end
        end
        tests++;
        if (mv_first !== FL) begin
            fails++;
            $display("FAIL basic_latency: m_valid at cycle %0d required %0d", mv_first, FL);
        end
        tests++;
        if (mv_n !== 1 || sr_hold !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold_cycle: m_valid cycles %0d s_ready %b required 1 and 0", mv_n, sr_hold);
        end
        tests++;
        if (o0 !== 5'b10110 || o1 !== 5'b01110) begin
            fails++;
            $display("FAIL basic_data: o0=%b o1=%b required 10110 01110", o0, o1);
        end
        tests++;
        if (s_ready !== 1'b1 || err_cnt !== e0) begin
            fails++;
            $display("FAIL basic_after: s_ready=%b errs=%0d required 1 and 0", s_ready, err_cnt - e0);
        end
    endtask

    task automatic test_hold;
        m_ready = 1'b0;
        send_frame(fr_b, 1'b0);
        for (int i = 0; i < 5; i++) tick;
        tests++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0 || o0 !== 5'b01101 || o1 !== 5'b10001) begin
            fails++;
            $display("FAIL hold_stable: m_valid=%b s_ready=%b o0=%b o1=%b required 1 0 01101 10001",
                     m_valid, s_ready, o0, o1);
        end
        m_ready = 1'b1;
        tick;
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || o0 !== 5'b01101 || o1 !== 5'b10001) begin
            fails++;
            $display("FAIL hold_release: m_valid=%b s_ready=%b o0=%b o1=%b required 0 1 01101 10001",
                     m_valid, s_ready, o0, o1);
        end
    endtask

    task automatic test_drop;
        drive(1'b1, 1'b1, 1'b0);
        tick;
        drive(1'b0, 1'b0, 1'b0);
        tests++;
        if (err !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_unflagged: err=%b m_valid=%b required 1 0", err, m_valid);
        end
        tick;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL drop_err_pulse: err=%b required 0", err);
        end
    endtask

    task automatic test_restart;
        int e0;
        e0 = err_cnt;
        send_part(fr_b, 4, 1'b1);
        tests++;
        if (o0 !== 5'b01101 || o1 !== 5'b10001) begin
            fails++;
            $display("FAIL restart_shadow: o0=%b o1=%b required 01101 10001", o0, o1);
        end
        send_frame(fr_a, 1'b0);
        tests++;
        if (m_valid !== 1'b1 || o0 !== 5'b10110 || o1 !== 5'b01110 || err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL restart_frame: m_valid=%b o0=%b o1=%b errs=%0d required 1 10110 01110 1",
                     m_valid, o0, o1, err_cnt - e0);
        end
        tick;
    endtask

    task automatic test_timeout;
        send_part(fr_b, 3, 1'b1);
        for (int i = 0; i < 9; i++) tick;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: err=%b required 0 after 9 idle cycles", err);
        end
        tick;
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_fire: err=%b required 1 after 10 idle cycles", err);
        end
        tick;
        tests++;
        if (err !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0 || o0 !== 5'b10110 || o1 !== 5'b01110) begin
            fails++;
            $display("FAIL timeout_after: err=%b s_ready=%b m_valid=%b o0=%b o1=%b required 0 1 0 10110 01110",
                     err, s_ready, m_valid, o0, o1);
        end
    endtask

`ifdef BIT_STREAM_UNPACKER_PARITY_EN
    task automatic test_parity;
        int e0;
        e0 = err_cnt;
        send_frame(fr_b, 1'b1);
        tick;
        tests++;
        if (m_valid !== 1'b0 || err_cnt - e0 !== 1 || o0 !== 5'b10110 || o1 !== 5'b01110) begin
            fails++;
            $display("FAIL parity_bad: m_valid=%b errs=%0d o0=%b o1=%b required 0 1 10110 01110",
                     m_valid, err_cnt - e0, o0, o1);
        end
        tick;
    endtask
`endif

    task automatic test_reset_mid;
        int e0;
        e0 = err_cnt;
        send_part(fr_b, 6, 1'b1);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({o0, o1, m_valid, s_ready, err} !== 13'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b required 0", {o0, o1, m_valid, s_ready, err});
        end
        tick;
        rst_n = 1'b1;
        tick;
        send_frame(fr_b, 1'b0);
        tests++;
        if (m_valid !== 1'b1 || o0 !== 5'b01101 || o1 !== 5'b10001 || err_cnt !== e0) begin
            fails++;
            $display("FAIL reset_mid_frame: m_valid=%b o0=%b o1=%b errs=%0d required 1 01101 10001 0",
                     m_valid, o0, o1, err_cnt - e0);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int e0;
        e0 = err_cnt;
        m_ready = 1'b1;
        send_frame(fr_a, 1'b0);
        tests++;
        if (m_valid !== 1'b1 || o0 !== 5'b10110) begin
            fails++;
            $display("FAIL b2b_first: m_valid=%b o0=%b required 1 10110", m_valid, o0);
        end
        tick;
        send_frame(fr_b, 1'b0);
        tests++;
        if (m_valid !== 1'b1 || o0 !== 5'b01101 || o1 !== 5'b10001 || err_cnt !== e0) begin
            fails++;
            $display("FAIL b2b_second: m_valid=%b o0=%b o1=%b errs=%0d required 1 01101 10001 0",
                     m_valid, o0, o1, err_cnt - e0);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_drop;
        test_restart;
        test_timeout;
`ifdef BIT_STREAM_UNPACKER_PARITY_EN
        test_parity;
`endif
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
